ysyx_25040111_axi_arbiter: RTL and testbench
============================================

Name: ysyx_25040111_axi_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter sitting directly downstream of the LSU and IFU memory ports; its slave side drives the SoC io_master bus.
- M0 is the IFU (read-only). M1 is the LSU (read and write).
- Exactly one transaction is outstanding at a time.
- The grant is registered, and the addressed channel is muxed through combinationally while the grant is held.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, AXI id width; the id is driven as 0 downstream

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- m0_arvalid/m0_arready  in/out  1/1  IFU read-address handshake
- m0_araddr/m0_arsize  in  32/3  IFU read address and size
- m0_rvalid/m0_rready  out/in  1/1  IFU read-data handshake
- m0_rdata/m0_rresp/m0_rlast  out  32/2/1  IFU read data, response, last
- m1_arvalid/m1_arready, m1_araddr/m1_arsize, m1_rvalid/m1_rready, m1_rdata/m1_rresp/m1_rlast  same widths and directions as the m0 read ports  LSU read channel
- m1_awvalid/m1_awready  in/out  1/1  LSU write-address handshake
- m1_awaddr/m1_awsize  in  32/3  LSU write address and size
- m1_wvalid/m1_wready  in/out  1/1  LSU write-data handshake
- m1_wdata/m1_wstrb/m1_wlast  in  32/4/1  LSU write data, strobe, last
- m1_bvalid/m1_bready  out/in  1/1  LSU write-response handshake
- m1_bresp  out  2  LSU write response
- io_master_ar*, r*, aw*, w*, b*  slave side  standard AXI4 widths; arid/awid=0, arlen/awlen=0, arburst/awburst=2'b01

Behaviour:
- Reset: state=IDLE, last_grant=M0. All outputs are 0: every valid, every ready, every data, resp and last field.
- States:
  - IDLE: nothing is forwarded; all upstream readies are 0.
  - RD0: M0 read granted.
  - RD1: M1 read granted.
  - WR1: M1 write granted.
- Request set in IDLE: m0_arvalid, m1_arvalid, (m1_awvalid | m1_wvalid).
- Default priority: WR1 > RD1 > RD0. The LSU gets priority so that a load/store is not starved by fetch.
- Grant is registered:
  - A request seen in cycle N gives the granted state at edge N+1.
  - The valid is forwarded to io_master from cycle N+1, so arbitration costs one bubble cycle.
- RDx:
  - io_master_ar* = mx_ar*, and mx_arready = io_master_arready.
  - io_master_rready = mx_rready, and mx_r* = io_master_r*.
  - The non-granted master sees arready=0 and rvalid=0.
- WR1:
  - aw, w and b are routed to/from M1.
  - AW and W may complete in either order or in the same cycle; the arbiter does not reorder them.
- Completion:
  - RDx → IDLE on io_master_rvalid & rready & rlast.
  - WR1 → IDLE on io_master_bvalid & bready.
  - A new grant is made no earlier than the following cycle, so there is no back-to-back forwarding.
- Responses: rresp/bresp pass through unmodified; error handling belongs to the master.
- Upstream valids must stay stable until the handshake (AXI rule). Dropping an ungranted request is legal; it is simply not granted.
- Simultaneous M1 read and write in IDLE: the write wins; the read waits.
- Async rst mid-transaction: immediate return to IDLE with all valids and readies 0. The downstream slave is reset by the same rst.
- No transaction is ever issued in the reset cycle or in the cycle after deassertion.

Optional Feature:
- Macro: YSYX_25040111_ARB_RR_EN
- When defined, reads use round-robin:
  - If both m0_arvalid and m1_arvalid are set, the master not in last_grant wins.
  - last_grant updates at each read completion.
  - Write is still highest priority.
- When undefined, fixed priority applies as above and last_grant is not synthesised.

Decomposition:
- Shared header (HDR/ysyx_25040111_inc.vh):
  - state encodings ARB_IDLE/ARB_RD0/ARB_RD1/ARB_WR1 (2 bits)
  - AXI burst INCR constant
  - AXI resp codes OKAY/SLVERR/DECERR
- One natural sub-module: ysyx_25040111_arb_pick. It is combinational: it takes the request vector and last_grant and returns the next state. It holds the priority/RR logic for independent unit testing.
- Channel muxing stays in the top module.

Test Plan:
- IFU read only: m0_arvalid=1, araddr=0x3000_0000 at cycle 0 → io_master_arvalid=1 at cycle 1. Slave returns rdata=0xDEADBEEF, rlast=1 → m0_rdata=0xDEADBEEF, m0_rvalid=1, then IDLE.
- Contention: m0_arvalid and m1_arvalid both asserted in the same cycle (fixed priority) → M1 is granted first (araddr=0x0F00_0010). M0 is granted only after M1's rlast, with one IDLE bubble between them.
- Store: m1_awaddr=0x0F00_0004, wdata=0x1234_5678, wstrb=4'b1100. Slave asserts awready 2 cycles before wready → both forwarded intact. bvalid → m1_bvalid=1, bresp=2'b00.
- Error passthrough: slave returns rresp=2'b10 on an M1 read → m1_rresp=2'b10. The state still returns to IDLE.
- Reset mid-read: rst pulsed while in RD0 with arvalid pending → all io_master valids and upstream readies are 0 within the same cycle (async). State is IDLE after deassert; a fresh request is then granted normally.
- RR (with YSYX_25040111_ARB_RR_EN): continuous m0_arvalid and m1_arvalid over 4 reads → grant order M1, M0, M1, M0.

Source files
------------

// File: rtl/ysyx_25040111_axi_arbiter_pkg.sv
// ============================================================================
// Module      : ysyx_25040111_axi_arbiter_pkg
// Description : Shared encodings for the IFU/LSU AXI4 arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25040111_axi_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_RD0  = 2'd1;
  localparam logic [1:0] ARB_RD1  = 2'd2;
  localparam logic [1:0] ARB_WR1  = 2'd3;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  // Bit positions in the arbitration request vector
  localparam int REQ_RD0 = 0;
  localparam int REQ_RD1 = 1;
  localparam int REQ_WR1 = 2;

endpackage

`default_nettype wire

// File: rtl/ysyx_25040111_axi_arbiter_pick.sv
// ============================================================================
// Module      : ysyx_25040111_arb_pick
// Description : Combinational grant selection from IDLE. Round-robin between
//               the two readers when YSYX_25040111_ARB_RR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040111_arb_pick
  import ysyx_25040111_axi_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic       last_grant,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = ARB_IDLE;
    if (req[REQ_WR1]) begin
      next_state = ARB_WR1;
    end
`ifdef YSYX_25040111_ARB_RR_EN
    else if (req[REQ_RD0] && req[REQ_RD1]) begin
      next_state = (last_grant == GRANT_M0) ? ARB_RD1 : ARB_RD0;
    end
`endif
    else if (req[REQ_RD1]) begin
      next_state = ARB_RD1;
    end else if (req[REQ_RD0]) begin
      next_state = ARB_RD0;
    end
  end

`ifndef YSYX_25040111_ARB_RR_EN
  logic w_unused_last;
  assign w_unused_last = last_grant;
`endif

endmodule

`default_nettype wire

// File: rtl/ysyx_25040111_axi_arbiter.sv
// ============================================================================
// Module      : ysyx_25040111_axi_arbiter
// Description : IFU (M0, read-only) / LSU (M1) to io_master AXI4 arbiter with
//               a registered grant and one transaction outstanding. Optional
//               read round-robin: YSYX_25040111_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040111_axi_arbiter
  import ysyx_25040111_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic [2:0]            m0_arsize,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,

  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic [2:0]            m1_arsize,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic [2:0]            m1_awsize,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wlast,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  output logic [1:0]            m1_bresp,

  output logic                  io_master_arvalid,
  input  logic                  io_master_arready,
  output logic [ADDR_W-1:0]     io_master_araddr,
  output logic [ID_W-1:0]       io_master_arid,
  output logic [7:0]            io_master_arlen,
  output logic [2:0]            io_master_arsize,
  output logic [1:0]            io_master_arburst,
  input  logic                  io_master_rvalid,
  output logic                  io_master_rready,
  input  logic [DATA_W-1:0]     io_master_rdata,
  input  logic [1:0]            io_master_rresp,
  input  logic                  io_master_rlast,
  output logic                  io_master_awvalid,
  input  logic                  io_master_awready,
  output logic [ADDR_W-1:0]     io_master_awaddr,
  output logic [ID_W-1:0]       io_master_awid,
  output logic [7:0]            io_master_awlen,
  output logic [2:0]            io_master_awsize,
  output logic [1:0]            io_master_awburst,
  output logic                  io_master_wvalid,
  input  logic                  io_master_wready,
  output logic [DATA_W-1:0]     io_master_wdata,
  output logic [DATA_W/8-1:0]   io_master_wstrb,
  output logic                  io_master_wlast,
  input  logic                  io_master_bvalid,
  output logic                  io_master_bready,
  input  logic [1:0]            io_master_bresp
);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [1:0] w_pick_state;
  logic [2:0] w_req;
  logic       w_last_grant;
  logic       w_rd_done;
  logic       w_wr_done;

  assign w_req[REQ_RD0] = m0_arvalid;
  assign w_req[REQ_RD1] = m1_arvalid;
  assign w_req[REQ_WR1] = m1_awvalid | m1_wvalid;

  assign w_rd_done = io_master_rvalid & io_master_rready & io_master_rlast;
  assign w_wr_done = io_master_bvalid & io_master_bready;

  ysyx_25040111_arb_pick u_pick (
    .req        (w_req),
    .last_grant (w_last_grant),
    .next_state (w_pick_state)
  );

`ifdef YSYX_25040111_ARB_RR_EN
  logic r_last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GRANT_M0;
    end else if (w_rd_done) begin
      r_last_grant <= (r_state == ARB_RD1) ? GRANT_M1 : GRANT_M0;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = GRANT_M0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grants are only made from IDLE, which enforces the bubble between transactions
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: w_next_state = w_pick_state;
      ARB_RD0,
      ARB_RD1:  if (w_rd_done) w_next_state = ARB_IDLE;
      ARB_WR1:  if (w_wr_done) w_next_state = ARB_IDLE;
      default:  w_next_state = ARB_IDLE;
    endcase
  end

  assign io_master_arid  = '0;
  assign io_master_awid  = '0;
  assign io_master_arlen = 8'd0;
  assign io_master_awlen = 8'd0;

  always_comb begin
    m0_arready        = 1'b0;
    m0_rvalid         = 1'b0;
    m0_rdata          = '0;
    m0_rresp          = 2'b00;
    m0_rlast          = 1'b0;
    m1_arready        = 1'b0;
    m1_rvalid         = 1'b0;
    m1_rdata          = '0;
    m1_rresp          = 2'b00;
    m1_rlast          = 1'b0;
    m1_awready        = 1'b0;
    m1_wready         = 1'b0;
    m1_bvalid         = 1'b0;
    m1_bresp          = 2'b00;
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arsize  = 3'd0;
    io_master_arburst = 2'b00;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = '0;
    io_master_awsize  = 3'd0;
    io_master_awburst = 2'b00;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;
    case (r_state)
      ARB_RD0: begin
        io_master_arvalid = m0_arvalid;
        io_master_araddr  = m0_araddr;
        io_master_arsize  = m0_arsize;
        io_master_arburst = AXI_BURST_INCR;
        m0_arready        = io_master_arready;
        io_master_rready  = m0_rready;
        m0_rvalid         = io_master_rvalid;
        m0_rdata          = io_master_rdata;
        m0_rresp          = io_master_rresp;
        m0_rlast          = io_master_rlast;
      end
      ARB_RD1: begin
        io_master_arvalid = m1_arvalid;
        io_master_araddr  = m1_araddr;
        io_master_arsize  = m1_arsize;
        io_master_arburst = AXI_BURST_INCR;
        m1_arready        = io_master_arready;
        io_master_rready  = m1_rready;
        m1_rvalid         = io_master_rvalid;
        m1_rdata          = io_master_rdata;
        m1_rresp          = io_master_rresp;
        m1_rlast          = io_master_rlast;
      end
      ARB_WR1: begin
        io_master_awvalid = m1_awvalid;
        io_master_awaddr  = m1_awaddr;
        io_master_awsize  = m1_awsize;
        io_master_awburst = AXI_BURST_INCR;
        m1_awready        = io_master_awready;
        io_master_wvalid  = m1_wvalid;
        io_master_wdata   = m1_wdata;
        io_master_wstrb   = m1_wstrb;
        io_master_wlast   = m1_wlast;
        m1_wready         = io_master_wready;
        io_master_bready  = m1_bready;
        m1_bvalid         = io_master_bvalid;
        m1_bresp          = io_master_bresp;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040111_axi_arbiter.sv
// ============================================================================
// Module      : tb_ysyx_25040111_axi_arbiter
// Description : Directed bench for the IFU/LSU AXI4 arbiter; the slave side is
//               driven by hand. Round-robin order is expected when
//               YSYX_25040111_ARB_RR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25040111_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_arvalid = 0, m0_arready, m0_rvalid, m0_rready = 0, m0_rlast;
  logic [31:0] m0_araddr = 0, m0_rdata;
  logic [2:0]  m0_arsize = 0;
  logic [1:0]  m0_rresp;

  logic        m1_arvalid = 0, m1_arready, m1_rvalid, m1_rready = 0, m1_rlast;
  logic [31:0] m1_araddr = 0, m1_rdata;
  logic [2:0]  m1_arsize = 0;
  logic [1:0]  m1_rresp;
  logic        m1_awvalid = 0, m1_awready, m1_wvalid = 0, m1_wready, m1_wlast = 0;
  logic [31:0] m1_awaddr = 0, m1_wdata = 0;
  logic [2:0]  m1_awsize = 0;
  logic [3:0]  m1_wstrb = 0;
  logic        m1_bvalid, m1_bready = 0;
  logic [1:0]  m1_bresp;

  logic        io_master_arvalid, io_master_arready = 0;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid, io_master_awid;
  logic [7:0]  io_master_arlen, io_master_awlen;
  logic [2:0]  io_master_arsize, io_master_awsize;
  logic [1:0]  io_master_arburst, io_master_awburst;
  logic        io_master_rvalid = 0, io_master_rready, io_master_rlast = 0;
  logic [31:0] io_master_rdata = 0;
  logic [1:0]  io_master_rresp = 0;
  logic        io_master_awvalid, io_master_awready = 0;
  logic [31:0] io_master_awaddr;
  logic        io_master_wvalid, io_master_wready = 0, io_master_wlast;
  logic [31:0] io_master_wdata;
  logic [3:0]  io_master_wstrb;
  logic        io_master_bvalid = 0, io_master_bready;
  logic [1:0]  io_master_bresp = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25040111_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen),
    .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready), .io_master_rdata(io_master_rdata),
    .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid), .io_master_awlen(io_master_awlen),
    .io_master_awsize(io_master_awsize), .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready), .io_master_wdata(io_master_wdata),
    .io_master_wstrb(io_master_wstrb), .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready), .io_master_bresp(io_master_bresp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    io_master_arready = 0;
    io_master_rvalid  = 0;
    io_master_rlast   = 0;
    io_master_rdata   = 0;
    io_master_rresp   = 0;
    io_master_awready = 0;
    io_master_wready  = 0;
    io_master_bvalid  = 0;
    io_master_bresp   = 0;
  endtask

  logic [31:0] exp_addr;

  initial begin
    // Reset state
    tick();
    tick();
    io_master_arready = 1;
    io_master_rvalid  = 1;
    io_master_bvalid  = 1;
    #1;
    chk("rst_io_arvalid", io_master_arvalid, 1'b0);
    chk("rst_m0_arready", m0_arready, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk("rst_m1_bvalid", m1_bvalid, 1'b0);
    chk("rst_io_rready", io_master_rready, 1'b0);
    clear_slave();
    tick();
    rst = 0;
    tick();

    // IFU read only
    m0_arvalid = 1; m0_araddr = 32'h3000_0000; m0_arsize = 3'd2;
    #1;
    chk("ifu_bubble_arvalid", io_master_arvalid, 1'b0);
    tick();
    chk("ifu_arvalid", io_master_arvalid, 1'b1);
    chk("ifu_araddr", io_master_araddr, 32'h3000_0000);
    chk("ifu_arsize", io_master_arsize, 3'd2);
    chk("ifu_arburst", io_master_arburst, 2'b01);
    chk("ifu_arlen", io_master_arlen, 8'd0);
    io_master_arready = 1;
    #1;
    chk("ifu_arready", m0_arready, 1'b1);
    chk("ifu_m1_arready", m1_arready, 1'b0);
    tick();
    m0_arvalid = 0; io_master_arready = 0;
    io_master_rvalid = 1; io_master_rdata = 32'hCAFE_0001; io_master_rlast = 0; m0_rready = 1;
    tick();
    chk("ifu_no_last_hold", m0_rvalid, 1'b1);
    io_master_rdata = 32'hDEAD_BEEF; io_master_rlast = 1;
    #1;
    chk("ifu_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("ifu_rlast", m0_rlast, 1'b1);
    chk("ifu_rready", io_master_rready, 1'b1);
    chk("ifu_m1_rvalid", m1_rvalid, 1'b0);
    tick();
    clear_slave(); m0_rready = 0;
    io_master_arready = 1;
    #1;
    chk("ifu_idle_arready", m0_arready, 1'b0);
    io_master_arready = 0;

    // Contention under fixed priority, plus SLVERR passthrough on M1
    m0_arvalid = 1; m0_araddr = 32'h3000_0004;
    m1_arvalid = 1; m1_araddr = 32'h0F00_0010; m1_arsize = 3'd2;
    tick();
    chk("cont_first_addr", io_master_araddr, 32'h0F00_0010);
    io_master_arready = 1;
    #1;
    chk("cont_m1_arready", m1_arready, 1'b1);
    chk("cont_m0_arready", m0_arready, 1'b0);
    tick();
    m1_arvalid = 0; io_master_arready = 0;
    io_master_rvalid = 1; io_master_rdata = 32'h1111_2222; io_master_rresp = 2'b10; io_master_rlast = 1;
    m1_rready = 1;
    #1;
    chk("err_m1_rdata", m1_rdata, 32'h1111_2222);
    chk("err_m1_rresp", m1_rresp, 2'b10);
    chk("cont_m0_rvalid", m0_rvalid, 1'b0);
    tick();
    clear_slave(); m1_rready = 0;
    #1;
    chk("cont_bubble_arvalid", io_master_arvalid, 1'b0);
    tick();
    chk("cont_second_arvalid", io_master_arvalid, 1'b1);
    chk("cont_second_addr", io_master_araddr, 32'h3000_0004);
    io_master_arready = 1;
    tick();
    m0_arvalid = 0; io_master_arready = 0;
    io_master_rvalid = 1; io_master_rlast = 1; m0_rready = 1;
    tick();
    clear_slave(); m0_rready = 0;

    // Store with AW accepted two cycles before W; concurrent M1 read must wait
    m1_awvalid = 1; m1_awaddr = 32'h0F00_0004; m1_awsize = 3'd2;
    m1_wvalid = 1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b1100; m1_wlast = 1;
    m1_bready = 1;
    m1_arvalid = 1; m1_araddr = 32'h0F00_0020;
    #1;
    chk("wr_bubble_awvalid", io_master_awvalid, 1'b0);
    tick();
    chk("wr_awvalid", io_master_awvalid, 1'b1);
    chk("wr_awaddr", io_master_awaddr, 32'h0F00_0004);
    chk("wr_wvalid", io_master_wvalid, 1'b1);
    chk("wr_wdata", io_master_wdata, 32'h1234_5678);
    chk("wr_wstrb", io_master_wstrb, 4'b1100);
    chk("wr_read_waits", io_master_arvalid, 1'b0);
    io_master_awready = 1;
    #1;
    chk("wr_m1_awready", m1_awready, 1'b1);
    chk("wr_m1_wready_early", m1_wready, 1'b0);
    tick();
    m1_awvalid = 0; io_master_awready = 0;
    tick();
    io_master_wready = 1;
    #1;
    chk("wr_m1_wready", m1_wready, 1'b1);
    chk("wr_wdata_late", io_master_wdata, 32'h1234_5678);
    chk("wr_wlast", io_master_wlast, 1'b1);
    tick();
    m1_wvalid = 0; io_master_wready = 0;
    io_master_bvalid = 1; io_master_bresp = 2'b00;
    #1;
    chk("wr_m1_bvalid", m1_bvalid, 1'b1);
    chk("wr_m1_bresp", m1_bresp, 2'b00);
    chk("wr_bready", io_master_bready, 1'b1);
    tick();
    clear_slave(); m1_bready = 0;
    tick();
    chk("wr_then_read_addr", io_master_araddr, 32'h0F00_0020);
    io_master_arready = 1;
    tick();
    m1_arvalid = 0; io_master_arready = 0;
    io_master_rvalid = 1; io_master_rlast = 1; m1_rready = 1;
    tick();
    clear_slave(); m1_rready = 0;

    // Asynchronous reset in the middle of an M0 read
    m0_arvalid = 1; m0_araddr = 32'h3000_0008;
    tick();
    chk("rstmid_granted", io_master_arvalid, 1'b1);
    io_master_arready = 1;
    #2;
    rst = 1;
    #1;
    chk("rstmid_arvalid", io_master_arvalid, 1'b0);
    chk("rstmid_m0_arready", m0_arready, 1'b0);
    tick();
    rst = 0;
    #1;
    chk("rstmid_idle_after", io_master_arvalid, 1'b0);
    tick();
    chk("rstmid_regrant", io_master_arvalid, 1'b1);
    chk("rstmid_regrant_addr", io_master_araddr, 32'h3000_0008);
    tick();
    m0_arvalid = 0; io_master_arready = 0;
    io_master_rvalid = 1; io_master_rlast = 1; m0_rready = 1;
    tick();
    clear_slave(); m0_rready = 0;

    // Four reads with both masters continuously requesting
    m0_arvalid = 1; m0_araddr = 32'h3000_0100;
    m1_arvalid = 1; m1_araddr = 32'h0F00_0100;
    m0_rready = 1; m1_rready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef YSYX_25040111_ARB_RR_EN
      exp_addr = (i % 2 == 0) ? 32'h0F00_0100 : 32'h3000_0100;
`else
      exp_addr = 32'h0F00_0100;
`endif
      chk($sformatf("order_%0d", i), io_master_araddr, exp_addr);
      io_master_arready = 1; io_master_rvalid = 1; io_master_rlast = 1;
      tick();
      clear_slave();
    end
    m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
